// File: rtl/mac_accumulator_4bits_if.sv
// Product-stream input and result output handshakes of the MAC accumulator stage.
// The slave modport is the accumulator's view; the master modport is the surrounding logic's view.
interface mac_accumulator_4bits_if #(
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned MAX_BEATS = 255,
    localparam int unsigned CNT_WIDTH = $clog2(MAX_BEATS + 1)
);

    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_product;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_overflow;
    logic                 out_truncated;

    modport slave (
        input  in_valid,
        input  in_product,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_count,
        output out_overflow,
        output out_truncated
    );

    modport master (
        output in_valid,
        output in_product,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_count,
        input  out_overflow,
        input  out_truncated
    );

endinterface

// File: rtl/mac_accumulator_4bits.sv
// Sums runs of 8-bit products into one result per vector, closed by in_last or a beat limit,
// with sticky overflow, optional saturation and a one-entry registered result slot.
module mac_accumulator_4bits #(
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned MAX_BEATS = 255,
    parameter int unsigned SATURATE  = 0,
    localparam int unsigned CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
    input logic                    clk,
    input logic                    rst_n,
    mac_accumulator_4bits_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    localparam logic [CNT_WIDTH:0] MaxCnt = (CNT_WIDTH + 1)'(MAX_BEATS);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_ovf;
    logic                 w_ovf_nxt;
    logic                 r_in_ready;

    logic                 r_out_valid;
    logic                 w_out_valid_nxt;
    logic [ACC_WIDTH-1:0] r_out_sum;
    logic [ACC_WIDTH-1:0] w_out_sum_nxt;
    logic [CNT_WIDTH-1:0] r_out_count;
    logic [CNT_WIDTH-1:0] w_out_count_nxt;
    logic                 r_out_ovf;
    logic                 w_out_ovf_nxt;
    logic                 r_out_trunc;
    logic                 w_out_trunc_nxt;

    logic                 w_beat;
    logic [ACC_WIDTH:0]   w_sum_wide;
    logic [CNT_WIDTH:0]   w_cnt_inc;
    logic                 w_close;
    logic                 w_ovf_beat;
    logic                 w_ovf_acc;
    logic [ACC_WIDTH-1:0] w_acc_beat;

    assign w_beat     = bus.in_valid & r_in_ready;
    assign w_sum_wide = {1'b0, r_acc} + {{(ACC_WIDTH - 7){1'b0}}, bus.in_product};
    assign w_cnt_inc  = {1'b0, r_cnt} + (CNT_WIDTH + 1)'(1);
    assign w_close    = bus.in_last | (w_cnt_inc == MaxCnt);
    assign w_ovf_beat = w_sum_wide[ACC_WIDTH];
    assign w_ovf_acc  = r_ovf | w_ovf_beat;
    // A saturated accumulator stays all-ones: any further nonzero product overflows again.
    assign w_acc_beat = ((SATURATE != 0) && w_ovf_beat) ? '1 : w_sum_wide[ACC_WIDTH-1:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_ovf_nxt       = r_ovf;
        w_out_valid_nxt = r_out_valid;
        w_out_sum_nxt   = r_out_sum;
        w_out_count_nxt = r_out_count;
        w_out_ovf_nxt   = r_out_ovf;
        w_out_trunc_nxt = r_out_trunc;
        unique case (r_state)
            StIdle, StAccum: begin
                if (w_beat) begin
                    if (w_close) begin
                        w_state_nxt     = StHold;
                        w_acc_nxt       = '0;
                        w_cnt_nxt       = '0;
                        w_ovf_nxt       = 1'b0;
                        w_out_valid_nxt = 1'b1;
                        w_out_sum_nxt   = w_acc_beat;
                        w_out_count_nxt = w_cnt_inc[CNT_WIDTH-1:0];
                        w_out_ovf_nxt   = w_ovf_acc;
                        w_out_trunc_nxt = ~bus.in_last;
                    end else begin
                        w_state_nxt = StAccum;
                        w_acc_nxt   = w_acc_beat;
                        w_cnt_nxt   = w_cnt_inc[CNT_WIDTH-1:0];
                        w_ovf_nxt   = w_ovf_acc;
                    end
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    w_state_nxt     = StIdle;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // in_ready is registered so it stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
            r_out_trunc <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ovf       <= w_ovf_nxt;
            r_in_ready  <= (w_state_nxt != StHold);
            r_out_valid <= w_out_valid_nxt;
            r_out_sum   <= w_out_sum_nxt;
            r_out_count <= w_out_count_nxt;
            r_out_ovf   <= w_out_ovf_nxt;
            r_out_trunc <= w_out_trunc_nxt;
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_sum       = r_out_sum;
    assign bus.out_count     = r_out_count;
    assign bus.out_overflow  = r_out_ovf;
    assign bus.out_truncated = r_out_trunc;

endmodule

// File: tb/tb_mac_accumulator_4bits.sv
// Bench for mac_accumulator_4bits: four configurations share one stimulus driver, selected by sel,
// and results are checked against a running-total model of the vector rules.
module tb_mac_accumulator_4bits;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    int          sel;
    int unsigned cfg_aw;
    int unsigned cfg_max;
    bit          cfg_sat;

    logic       drv_valid;
    logic       drv_last;
    logic       drv_oready;
    logic [7:0] drv_prod;

    longint mdl_total;
    int     mdl_cnt;

    mac_accumulator_4bits_if #(.ACC_WIDTH(16), .MAX_BEATS(255)) if0 ();
    mac_accumulator_4bits_if #(.ACC_WIDTH(10), .MAX_BEATS(255)) if1 ();
    mac_accumulator_4bits_if #(.ACC_WIDTH(10), .MAX_BEATS(255)) if2 ();
    mac_accumulator_4bits_if #(.ACC_WIDTH(16), .MAX_BEATS(3))   if3 ();

    mac_accumulator_4bits #(.ACC_WIDTH(16), .MAX_BEATS(255), .SATURATE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    mac_accumulator_4bits #(.ACC_WIDTH(10), .MAX_BEATS(255), .SATURATE(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mac_accumulator_4bits #(.ACC_WIDTH(10), .MAX_BEATS(255), .SATURATE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));
    mac_accumulator_4bits #(.ACC_WIDTH(16), .MAX_BEATS(3), .SATURATE(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave));

    assign if0.in_valid   = drv_valid && (sel == 0);
    assign if1.in_valid   = drv_valid && (sel == 1);
    assign if2.in_valid   = drv_valid && (sel == 2);
    assign if3.in_valid   = drv_valid && (sel == 3);
    assign if0.out_ready  = drv_oready && (sel == 0);
    assign if1.out_ready  = drv_oready && (sel == 1);
    assign if2.out_ready  = drv_oready && (sel == 2);
    assign if3.out_ready  = drv_oready && (sel == 3);
    assign if0.in_product = drv_prod;
    assign if1.in_product = drv_prod;
    assign if2.in_product = drv_prod;
    assign if3.in_product = drv_prod;
    assign if0.in_last    = drv_last;
    assign if1.in_last    = drv_last;
    assign if2.in_last    = drv_last;
    assign if3.in_last    = drv_last;

    logic        m_in_ready;
    logic        m_out_valid;
    logic [15:0] m_sum;
    logic [7:0]  m_cnt;
    logic        m_ovf;
    logic        m_trunc;

    always_comb begin
        m_in_ready  = if0.in_ready;
        m_out_valid = if0.out_valid;
        m_sum       = if0.out_sum;
        m_cnt       = if0.out_count;
        m_ovf       = if0.out_overflow;
        m_trunc     = if0.out_truncated;
        case (sel)
            1: begin
                m_in_ready  = if1.in_ready;
                m_out_valid = if1.out_valid;
                m_sum       = 16'(if1.out_sum);
                m_cnt       = if1.out_count;
                m_ovf       = if1.out_overflow;
                m_trunc     = if1.out_truncated;
            end
            2: begin
                m_in_ready  = if2.in_ready;
                m_out_valid = if2.out_valid;
                m_sum       = 16'(if2.out_sum);
                m_cnt       = if2.out_count;
                m_ovf       = if2.out_overflow;
                m_trunc     = if2.out_truncated;
            end
            3: begin
                m_in_ready  = if3.in_ready;
                m_out_valid = if3.out_valid;
                m_sum       = if3.out_sum;
                m_cnt       = 8'(if3.out_count);
                m_ovf       = if3.out_overflow;
                m_trunc     = if3.out_truncated;
            end
            default: ;
        endcase
    end

    task automatic select_dut(input int k);
        sel       = k;
        cfg_aw    = (k == 1 || k == 2) ? 10 : 16;
        cfg_max   = (k == 3) ? 3 : 255;
        cfg_sat   = (k == 2);
        mdl_total = 0;
        mdl_cnt   = 0;
        #1;
    endtask

    task automatic send_beat(input logic [7:0] p, input logic l);
        int n;
        @(negedge clk);
        drv_valid = 1'b1;
        drv_prod  = p;
        drv_last  = l;
        n = 0;
        while (m_in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (m_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_accept: in_ready=%b after %0d cycles, required 1", m_in_ready, n);
        end
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
    endtask

    task automatic get_result(output logic [15:0] s, output logic [7:0] c, output logic o,
                              output logic t);
        int n;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        drv_oready = 1'b1;
        n = 0;
        while (m_out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (m_out_valid !== 1'b1) begin
            bad++;
            $display("FAIL result_wait: out_valid=%b, required 1", m_out_valid);
        end
        s = m_sum;
        c = m_cnt;
        o = m_ovf;
        t = m_trunc;
        @(posedge clk);
        #1;
        drv_oready = 1'b0;
        total++;
        if (m_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL out_drop: out_valid=%b after transfer, required 0", m_out_valid);
        end
    endtask

    // Model: a vector is an unbounded running total; wrap/clamp only when the result is read.
    task automatic run_beat(input logic [7:0] p, input logic l);
        logic [15:0] s;
        logic [7:0]  c;
        logic        o;
        logic        t;
        longint      lim;
        longint      es;
        send_beat(p, l);
        mdl_total += longint'(p);
        mdl_cnt++;
        if (l || mdl_cnt == int'(cfg_max)) begin
            lim = longint'(1) << cfg_aw;
            es  = cfg_sat ? ((mdl_total >= lim) ? lim - 1 : mdl_total) : mdl_total % lim;
            total++;
            if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0) begin
                bad++;
                $display("FAIL latency: out_valid=%b in_ready=%b, required 1 0",
                         m_out_valid, m_in_ready);
            end
            get_result(s, c, o, t);
            total++;
            if (s !== 16'(es)) begin
                bad++;
                $display("FAIL sum: got %0d, required %0d (dut %0d)", s, es, sel);
            end
            total++;
            if (c !== 8'(mdl_cnt)) begin
                bad++;
                $display("FAIL count: got %0d, required %0d (dut %0d)", c, mdl_cnt, sel);
            end
            total++;
            if (o !== (mdl_total >= lim)) begin
                bad++;
                $display("FAIL overflow: got %b, required %b (dut %0d)", o, mdl_total >= lim, sel);
            end
            total++;
            if (t !== !l) begin
                bad++;
                $display("FAIL truncated: got %b, required %b (dut %0d)", t, !l, sel);
            end
            mdl_total = 0;
            mdl_cnt   = 0;
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({m_in_ready, m_out_valid, m_sum, m_cnt, m_ovf, m_trunc} !== 28'd0) begin
            bad++;
            $display("FAIL %s: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b trunc=%b, required all 0",
                     name, m_in_ready, m_out_valid, m_sum, m_cnt, m_ovf, m_trunc);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b1;
        drv_valid  = 1'b0;
        drv_last   = 1'b0;
        drv_oready = 1'b0;
        drv_prod   = 8'd0;
        select_dut(0);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            select_dut(k);
            check_zero("reset_outputs");
        end
        select_dut(0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (m_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge: in_ready=%b, required 0", m_in_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (m_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_edge: in_ready=%b, required 1", m_in_ready);
        end
    endtask

    task automatic test_basic();
        select_dut(0);
        for (int i = 0; i < 4; i++) run_beat(8'd225, i == 3);
    endtask

    task automatic test_wrap_saturate();
        for (int k = 1; k < 3; k++) begin
            select_dut(k);
            for (int i = 0; i < 5; i++) run_beat(8'd225, i == 4);
        end
    endtask

    task automatic test_single();
        select_dut(0);
        run_beat(8'h2A, 1'b1);
        run_beat(8'd3, 1'b0);
        run_beat(8'd4, 1'b1);
    endtask

    task automatic test_stall();
        logic [15:0] s;
        logic [7:0]  c;
        logic        o;
        logic        t;
        select_dut(0);
        send_beat(8'd11, 1'b0);
        send_beat(8'd22, 1'b1);
        @(negedge clk);
        drv_valid = 1'b1;
        drv_prod  = 8'd99;
        drv_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (m_in_ready !== 1'b0 || m_out_valid !== 1'b1 || m_sum !== 16'd33 ||
                m_cnt !== 8'd2) begin
                bad++;
                $display("FAIL stall_hold: rdy=%b vld=%b sum=%0d cnt=%0d, required 0 1 33 2",
                         m_in_ready, m_out_valid, m_sum, m_cnt);
            end
        end
        get_result(s, c, o, t);
        total++;
        if (s !== 16'd33 || c !== 8'd2 || o !== 1'b0 || t !== 1'b0) begin
            bad++;
            $display("FAIL stall_result: sum=%0d cnt=%0d ovf=%b trunc=%b, required 33 2 0 0",
                     s, c, o, t);
        end
        // The held beat is accepted right after the bubble; re-presenting it must not duplicate it.
        run_beat(8'd99, 1'b0);
        run_beat(8'd1, 1'b1);
    endtask

    task automatic test_truncate();
        select_dut(3);
        run_beat(8'd10, 1'b0);
        run_beat(8'd20, 1'b0);
        run_beat(8'd30, 1'b0);
        run_beat(8'd5, 1'b1);
    endtask

    task automatic test_reset_mid();
        select_dut(0);
        send_beat(8'd3, 1'b0);
        send_beat(8'd4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_vector");
        @(negedge clk);
        rst_n = 1'b1;
        run_beat(8'd5, 1'b1);
        send_beat(8'd8, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset_in_hold");
        @(negedge clk);
        rst_n = 1'b1;
        run_beat(8'd6, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] p;
        logic       l;
        for (int k = 0; k < 4; k++) begin
            select_dut(k);
            for (int i = 0; i < 40; i++) begin
                p = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                l = ($urandom_range(0, 3) == 0);
                run_beat(p, l);
            end
            if (mdl_cnt != 0) run_beat(8'd1, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_saturate();
        test_single();
        test_stall();
        test_truncate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
